// File: rtl/iram_loader_pkg.sv
// iram_loader_pkg: shared state encoding and sizing constants for the IRAM loader
package iram_loader_pkg;
  localparam int IRAM_ADR_W = 12;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    RB_ADR  = 3'd3,
    RB_CAP  = 3'd4
  } state_t;
endpackage

// File: rtl/iram_word_packer.sv
// iram_word_packer: packs a byte stream into 32-bit words with selectable lane order
module iram_word_packer
  import iram_loader_pkg::*;
#(
  parameter bit LITTLE_END = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strobe_i,
  input  logic [7:0]  byte_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  lane;
  // lane insert and byte-index advance; clear wins over a simultaneous byte
  always_comb begin
    lane = LITTLE_END ? idx_q : ~idx_q;
    idx_d = clear_i ? 2'd0 : strobe_i ? idx_q + 2'd1 : idx_q;
    word_d = clear_i ? 32'd0 : word_q;
    if (strobe_i && !clear_i) word_d[{lane, 3'b000} +: 8] = byte_i;
  end
  // byte index and partial word storage
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end
  assign word_o       = word_q;
  assign word_ready_o = strobe_i && !clear_i && idx_q == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/iram_loader.sv
// iram_loader: byte-stream loader and single-word readback engine for the instruction RAM
module iram_loader
  import iram_loader_pkg::*;
#(
  parameter int ADR_W      = IRAM_ADR_W,
  parameter int CNT_W      = 13,
  parameter bit LITTLE_END = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_start,
  input  logic [ADR_W-1:0] ld_adr,
  input  logic [CNT_W-1:0] ld_words,
  input  logic             ld_abort,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic [ADR_W-1:0] i_ram_wadr,
  output logic [31:0]      i_ram_wdata,
  output logic             i_ram_wen,
  input  logic             rb_req,
  input  logic [ADR_W-1:0] rb_adr,
  output logic             i_read_sel,
  output logic [ADR_W-1:0] i_ram_radr,
  input  logic [31:0]      i_ram_rdata,
  output logic             rb_valid,
  output logic [31:0]      rb_data,
  output logic             ld_busy,
  output logic             ld_done
);
  state_t           state_q, state_d;
  logic [ADR_W-1:0] ptr_q, ptr_d, rb_adr_q, rb_adr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rb_data_q, rb_data_d, word;
  logic             rb_valid_q, rb_valid_d, zero_done_q, zero_done_d;
  logic             word_ready, start_ld, last_word;
  assign start_ld  = state_q == IDLE && ld_start && ld_words != '0;
  assign last_word = cnt_q == CNT_W'(1);
  iram_word_packer #(.LITTLE_END(LITTLE_END)) u_packer (
    .clk          (clk),
    .rst          (rst),
    .strobe_i     (rx_valid & rx_ready),
    .byte_i       (rx_data),
    .clear_i      (state_q != COLLECT || ld_abort),
    .word_o       (word),
    .word_ready_o (word_ready)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  // next state; abort from any busy state returns to IDLE, start beats readback
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_ld ? COLLECT : (rb_req && !ld_start) ? RB_ADR : IDLE;
      COLLECT: state_d = word_ready ? WRITE : COLLECT;
      WRITE:   state_d = last_word ? IDLE : COLLECT;
      RB_ADR:  state_d = RB_CAP;
      RB_CAP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ld_abort && state_q != IDLE) state_d = IDLE;
  end
  // datapath next values: write pointer, word counter, readback capture, zero-length done
  always_comb begin
    ptr_d       = start_ld ? ld_adr : state_q == WRITE ? ptr_q + 1'b1 : ptr_q;
    cnt_d       = start_ld ? ld_words : state_q == WRITE ? cnt_q - 1'b1 : cnt_q;
    rb_adr_d    = (state_q == IDLE && rb_req && !ld_start) ? rb_adr : rb_adr_q;
    rb_valid_d  = state_q == RB_CAP && !ld_abort;
    rb_data_d   = rb_valid_d ? i_ram_rdata : rb_data_q;
    zero_done_d = state_q == IDLE && ld_start && ld_words == '0;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      rb_adr_q    <= '0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      rb_adr_q    <= rb_adr_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
      zero_done_q <= zero_done_d;
    end
  end
  // outputs decoded from the current state; read select and write strobe are exclusive by state
  always_comb begin
    rx_ready    = state_q == COLLECT;
    i_ram_wen   = state_q == WRITE;
    i_ram_wadr  = ptr_q;
    i_ram_wdata = word;
    i_read_sel  = state_q == RB_ADR || state_q == RB_CAP;
    i_ram_radr  = rb_adr_q;
    rb_valid    = rb_valid_q;
    rb_data     = rb_data_q;
    ld_busy     = state_q != IDLE;
    ld_done     = zero_done_q || (state_q == WRITE && last_word && !ld_abort);
  end
endmodule

// File: tb/tb_iram_loader.sv
// tb_iram_loader: scoreboard bench for the IRAM loader with a synchronous RAM model
module tb_iram_loader;
  logic        clk = 0, rst = 1;
  logic        ld_start = 0, ld_abort = 0, rx_valid = 0, rb_req = 0;
  logic [11:0] ld_adr = 0, rb_adr = 0;
  logic [12:0] ld_words = 0;
  logic [7:0]  rx_data = 0;
  logic        rx_ready, i_ram_wen, i_read_sel, rb_valid, ld_busy, ld_done;
  logic [11:0] i_ram_wadr, i_ram_radr;
  logic [31:0] i_ram_wdata, i_ram_rdata, rb_data;
  logic [31:0] mem [0:4095];
  typedef struct {logic [11:0] adr; logic [31:0] data; logic last;} wr_t;
  wr_t         wq[$];
  wr_t         e_w;
  logic [31:0] rq[$];
  int errors = 0, checks = 0, wen_cnt = 0, done_cnt = 0, rbv_cnt = 0;
  int w0, d0, r0;

  iram_loader dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_adr(ld_adr), .ld_words(ld_words),
    .ld_abort(ld_abort), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .i_ram_wadr(i_ram_wadr), .i_ram_wdata(i_ram_wdata), .i_ram_wen(i_ram_wen),
    .rb_req(rb_req), .rb_adr(rb_adr), .i_read_sel(i_read_sel), .i_ram_radr(i_ram_radr),
    .i_ram_rdata(i_ram_rdata), .rb_valid(rb_valid), .rb_data(rb_data),
    .ld_busy(ld_busy), .ld_done(ld_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (i_ram_wen) mem[i_ram_wadr] <= i_ram_wdata;
    i_ram_rdata <= mem[i_ram_radr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (i_ram_wen) begin
        wen_cnt++;
        check("wen_expected", 64'(wq.size() != 0), 1);
        if (wq.size() != 0) begin
          e_w = wq.pop_front();
          check("wadr", i_ram_wadr, e_w.adr);
          check("wdata", i_ram_wdata, e_w.data);
          check("done_with_wen", ld_done, e_w.last);
          check("rsel_during_wen", i_read_sel, 0);
        end
      end
      if (ld_done) done_cnt++;
      if (rb_valid) begin
        rbv_cnt++;
        check("rb_expected", 64'(rq.size() != 0), 1);
        if (rq.size() != 0) check("rb_data", rb_data, rq.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    rx_valid = 0;
    repeat (gap) tick();
    rx_valid = 1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("rx_ready_timeout", rx_ready, 1);
    tick();
    rx_valid = 0;
  endtask

  task automatic start_load(input logic [11:0] adr, input logic [12:0] words, input logic rb);
    ld_start = 1;
    ld_adr   = adr;
    ld_words = words;
    rb_req   = rb;
    rb_adr   = 12'h040;
    tick();
    ld_start = 0;
    rb_req   = 0;
  endtask

  task automatic load_word(input logic [11:0] adr, input logic [31:0] w, input logic last, input int maxgap);
    wq.push_back('{adr, w, last});
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], $urandom_range(0, maxgap));
  endtask

  initial begin
    repeat (3) tick();
    check("rst_rx_ready", rx_ready, 0);
    check("rst_busy", ld_busy, 0);
    check("rst_wadr", i_ram_wadr, 0);
    check("rst_wdata", i_ram_wdata, 0);
    rst = 0;
    tick();
    // single word, little-endian
    start_load(12'h010, 13'd1, 0);
    load_word(12'h010, 32'h00100513, 1, 0);
    check("t1_wen", i_ram_wen, 1);
    check("t1_done", ld_done, 1);
    tick();
    check("t1_busy_falls", ld_busy, 0);
    // readback timing
    rb_req = 1;
    rb_adr = 12'h010;
    rq.push_back(32'h00100513);
    tick();
    rb_req = 0;
    check("t3_sel_t1", i_read_sel, 1);
    check("t3_radr_t1", i_ram_radr, 12'h010);
    check("t3_valid_t1", rb_valid, 0);
    tick();
    check("t3_sel_t2", i_read_sel, 1);
    check("t3_valid_t2", rb_valid, 0);
    tick();
    check("t3_valid_t3", rb_valid, 1);
    check("t3_data", rb_data, 32'h00100513);
    tick();
    check("t3_valid_pulse", rb_valid, 0);
    // address wrap with gaps
    w0 = wen_cnt;
    start_load(12'hFFF, 13'd2, 0);
    load_word(12'hFFF, $urandom, 0, 3);
    load_word(12'h000, $urandom, 1, 3);
    tick();
    check("t2_wen_count", wen_cnt - w0, 2);
    // abort mid-word
    w0 = wen_cnt;
    d0 = done_cnt;
    start_load(12'h100, 13'd3, 0);
    load_word(12'h100, $urandom, 0, 1);
    send(8'hAA, 0);
    send(8'hBB, 1);
    ld_abort = 1;
    tick();
    ld_abort = 0;
    check("t4_idle", ld_busy, 0);
    repeat (3) tick();
    check("t4_wen_count", wen_cnt - w0, 1);
    check("t4_no_done", done_cnt - d0, 0);
    start_load(12'h200, 13'd1, 0);
    load_word(12'h200, 32'hA1B2C3D4, 1, 0);
    tick();
    // simultaneous start and readback request
    r0 = rbv_cnt;
    start_load(12'h020, 13'd1, 1);
    load_word(12'h020, $urandom, 1, 0);
    repeat (5) tick();
    check("t5a_no_rb_valid", rbv_cnt - r0, 0);
    // zero-length load
    w0 = wen_cnt;
    d0 = done_cnt;
    ld_start = 1;
    ld_words = 0;
    tick();
    ld_start = 0;
    check("t5b_done", ld_done, 1);
    check("t5b_busy", ld_busy, 0);
    tick();
    check("t5b_done_pulse", ld_done, 0);
    repeat (3) tick();
    check("t5b_wen_count", wen_cnt - w0, 0);
    check("t5b_done_count", done_cnt - d0, 1);
    // reset mid-load
    w0 = wen_cnt;
    start_load(12'h300, 13'd2, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    rst = 1;
    tick();
    check("t6_rx_ready", rx_ready, 0);
    check("t6_wen", i_ram_wen, 0);
    check("t6_busy", ld_busy, 0);
    check("t6_done", ld_done, 0);
    check("t6_rsel", i_read_sel, 0);
    check("t6_rb_valid", rb_valid, 0);
    check("t6_wadr", i_ram_wadr, 0);
    check("t6_wdata", i_ram_wdata, 0);
    check("t6_radr", i_ram_radr, 0);
    check("t6_rb_data", rb_data, 0);
    rst = 0;
    repeat (10) tick();
    check("t6_no_wen", wen_cnt - w0, 0);
    check("wq_drained", wq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
